// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the four-way memory port arbiter.
package mem_arb_pkg;

    localparam int REQ_LOAD = 0;
    localparam int REQ_VID  = 1;
    localparam int REQ_CPU  = 2;
    localparam int REQ_FDD  = 3;

    localparam int MAX_WAIT_DEF = 15;
    localparam int TIMEOUT_DEF  = 63;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

    // Index of the lowest set bit (0 when none are set).
    function automatic logic [1:0] first_set(input logic [3:0] v);
        first_set = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (v[i]) first_set = 2'(i);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection: loader first, then aged requesters, then lowest pending index.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [3:0] aged,
    output logic [1:0] idx,
    output logic       valid
);

    logic [3:0] aged_req;

    always_comb begin
        // The loader never ages, so only bits 1..3 can take the aged path.
        aged_req = aged & req & 4'b1110;
        valid    = |req;
        if (req[REQ_LOAD])
            idx = 2'(REQ_LOAD);
        else if (|aged_req)
            idx = first_set(aged_req);
        else
            idx = first_set(req);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the 8-bit SDRAM port among loader, video, CPU and FDD with fixed
// priority plus aging; one strobe/ready transaction in flight, watchdog guarded.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 25,
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
)(
    input  logic            clk_sys,
    input  logic            reset,
    input  logic [3:0]      req,
    input  logic [3:0]      req_we,
    input  logic [4*AW-1:0] req_addr,
    input  logic [31:0]     req_din,
    output logic [3:0]      ack,
    output logic [3:0]      err,
    output logic [7:0]      rdata,
    output logic [AW-1:0]   mem_addr,
    output logic [7:0]      mem_din,
    output logic            mem_we,
    output logic            mem_rd,
    input  logic [7:0]      mem_dout,
    input  logic            mem_ready
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    arb_state_t         state, state_nxt;
    logic [1:0]         grant;
    logic               grant_we;
    logic               abort;
    logic [7:0]         hold;
    logic [WDW-1:0]     wd_cnt;
    logic               wd_expire;
    logic [3:1][3:0]    wait_cnt;
    logic [3:0]         aged;
    logic [1:0]         pick_idx;
    logic               pick_valid;
    logic [AW-1:0]      addr_sel;
    logic [7:0]         din_sel;

    mem_arb_pick u_pick (
        .req   (req),
        .aged  (aged),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        addr_sel = req_addr[0 +: AW];
        din_sel  = req_din[0 +: 8];
        for (int i = 1; i < 4; i++) begin
            if (pick_idx == 2'(i)) begin
                addr_sel = req_addr[i*AW +: AW];
                din_sel  = req_din[i*8 +: 8];
            end
        end
    end

    assign wd_expire = (wd_cnt == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            // The acked requester still shows req in the ack cycle, so arbitration
            // waits one more cycle to avoid granting it a second time.
            IDLE:    if (pick_valid && ack == 4'd0) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (mem_ready || wd_expire) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd = 1'b0;
        mem_we = 1'b0;
        if (state == ISSUE) begin
            mem_rd = !grant_we;
            mem_we = grant_we;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            grant    <= 2'd0;
            grant_we <= 1'b0;
            mem_addr <= '0;
            mem_din  <= 8'h00;
            abort    <= 1'b0;
            hold     <= 8'h00;
            wd_cnt   <= '0;
            ack      <= 4'd0;
            err      <= 4'd0;
            rdata    <= 8'h00;
        end else begin
            ack <= 4'd0;
            err <= 4'd0;
            case (state)
                IDLE: begin
                    if (state_nxt == ISSUE) begin
                        grant    <= pick_idx;
                        grant_we <= req_we[pick_idx];
                        mem_addr <= addr_sel;
                        mem_din  <= din_sel;
                        abort    <= 1'b0;
                    end
                end
                ISSUE: wd_cnt <= '0;
                WAIT: begin
                    // A ready coinciding with expiry is treated as success.
                    if (mem_ready) begin
                        if (!grant_we) hold <= mem_dout;
                    end else if (wd_expire) begin
                        hold  <= 8'hFF;
                        abort <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                DONE: begin
                    ack[grant] <= 1'b1;
                    err[grant] <= abort;
                    if (abort)          rdata <= 8'hFF;
                    else if (!grant_we) rdata <= hold;
                end
                default: ;
            endcase
        end
    end

    // Aging: count cycles a requester is pending but not being served.
    always_ff @(posedge clk_sys) begin
        for (int i = REQ_VID; i <= REQ_FDD; i++) begin
            if (reset || !req[i] || (state == DONE && grant == 2'(i)))
                wait_cnt[i] <= 4'd0;
            else if (!(state != IDLE && grant == 2'(i)) && wait_cnt[i] != 4'(MAX_WAIT))
                wait_cnt[i] <= wait_cnt[i] + 4'd1;
        end
    end

    always_comb begin
        aged = 4'd0;
        for (int i = REQ_VID; i <= REQ_FDD; i++)
            aged[i] = (wait_cnt[i] == 4'(MAX_WAIT));
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-timeline model compared every cycle,
// plus directed scenarios with hand-computed latencies and data.
module tb_mem_arbiter;

    localparam int AW       = 25;
    localparam int MAX_WAIT = 15;
    localparam int TIMEOUT  = 63;

    logic            clk_sys;
    logic            reset;
    logic [3:0]      req, req_we;
    logic [4*AW-1:0] req_addr;
    logic [31:0]     req_din;
    logic [3:0]      ack, err;
    logic [7:0]      rdata;
    logic [AW-1:0]   mem_addr;
    logic [7:0]      mem_din;
    logic            mem_we, mem_rd;
    logic [7:0]      mem_dout  = 8'hEE;
    logic            mem_ready = 1'b0;

    mem_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys(clk_sys), .reset(reset), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_din(req_din), .ack(ack), .err(err),
        .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_dout(mem_dout), .mem_ready(mem_ready)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    bit chk_en = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory responder: ready arrives mem_lat cycles after the strobe (0 = never).
    int mem_lat = 3;
    logic [7:0] mem_data = 8'h00;
    int ready_at = -1;

    always begin
        @(posedge clk_sys); #1;
        mem_ready = (ready_at >= 0 && cyc == ready_at);
        mem_dout  = mem_ready ? mem_data : 8'hEE;
    end

    // Activity log used by the directed checks.
    int n_strobe = 0, s_cyc = -1;
    logic s_we;
    logic [AW-1:0] s_addr;
    logic [7:0] s_din;
    int ack_cnt[4] = '{0, 0, 0, 0};
    logic [3:0] err_seen = 4'd0;

    always @(negedge clk_sys) begin
        if (mem_rd || mem_we) begin
            n_strobe++;
            s_cyc  = cyc;
            s_we   = mem_we;
            s_addr = mem_addr;
            s_din  = mem_din;
            ready_at = (mem_lat > 0) ? cyc + mem_lat : -1;
        end
        for (int i = 0; i < 4; i++) if (ack[i] === 1'b1) ack_cnt[i]++;
        err_seen = err_seen | err;
    end

    // Model: one transaction timeline (grant cycle, completion cycle) plus
    // per-requester pending-time ages.
    bit   m_busy = 0, m_done_set = 0, m_abort = 0, m_we = 0, m_ackout = 0;
    int   m_gnt = 0, m_done = 0, m_g = 0;
    logic [7:0] m_data;
    int   m_age[4] = '{0, 0, 0, 0};
    logic [3:0] e_ack = 4'd0, e_err = 4'd0;
    logic [7:0] e_rdata = 8'h00, e_din = 8'h00;
    logic [AW-1:0] e_addr = '0;
    logic e_rd = 0, e_we = 0;

    always @(posedge clk_sys) begin
        bit busy_pre, was_ack;
        int g_pre, win;
        cyc++;
        busy_pre = m_busy;
        g_pre    = m_g;
        e_ack = 4'd0; e_err = 4'd0; e_rd = 0; e_we = 0;
        if (reset) begin
            m_busy = 0; m_ackout = 0; m_done_set = 0;
            e_rdata = 8'h00; e_addr = '0; e_din = 8'h00;
            for (int i = 0; i < 4; i++) m_age[i] = 0;
        end else begin
            was_ack  = m_ackout;
            m_ackout = 0;
            if (m_busy && !m_done_set && cyc >= m_gnt + 2) begin
                if (mem_ready) begin
                    m_done_set = 1; m_done = cyc; m_abort = 0; m_data = mem_dout;
                end else if (cyc - m_gnt - 1 == TIMEOUT) begin
                    m_done_set = 1; m_done = cyc; m_abort = 1;
                end
            end
            if (m_busy && m_done_set && cyc == m_done + 1) begin
                e_ack[m_g] = 1'b1;
                e_err[m_g] = m_abort;
                if (m_abort)   e_rdata = 8'hFF;
                else if (!m_we) e_rdata = m_data;
                m_ackout = 1;
                m_busy   = 0;
            end else if (!m_busy && !was_ack && req != 4'd0) begin
                win = -1;
                if (req[0]) win = 0;
                else begin
                    for (int i = 3; i >= 1; i--) if (req[i] && m_age[i] == MAX_WAIT) win = i;
                    if (win < 0) for (int i = 3; i >= 1; i--) if (req[i]) win = i;
                end
                m_busy = 1; m_done_set = 0; m_gnt = cyc; m_g = win;
                m_we   = req_we[win];
                e_addr = req_addr[win*AW +: AW];
                e_din  = req_din[win*8 +: 8];
                e_rd   = !m_we;
                e_we   = m_we;
            end
            for (int i = 1; i < 4; i++) begin
                if (!req[i]) m_age[i] = 0;
                else if (busy_pre && g_pre == i) begin
                    if (m_done_set && cyc == m_done + 1) m_age[i] = 0;
                end else if (m_age[i] < MAX_WAIT) m_age[i]++;
            end
        end
    end

    always @(negedge clk_sys) begin
        if (chk_en) begin
            check("ack",      ack,      e_ack);
            check("err",      err,      e_err);
            check("rdata",    rdata,    e_rdata);
            check("mem_addr", mem_addr, e_addr);
            check("mem_din",  mem_din,  e_din);
            check("mem_rd",   mem_rd,   e_rd);
            check("mem_we",   mem_we,   e_we);
        end
    end

    task automatic step();
        @(posedge clk_sys); #1;
    endtask

    task automatic wait_ack(input int i, input int budget, output int at, output logic e);
        at = -1;
        e  = 1'bx;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk_sys);
            if (ack[i] === 1'b1) begin
                at = cyc;
                e  = err[i];
                break;
            end
        end
        if (at < 0) begin
            n_chk++;
            n_err++;
            $display("FAIL ack%0d_timeout: no ack within %0d cycles", i, budget);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, at, a0, s0, first;
        logic e;
        reset = 1; req = 4'd0; req_we = 4'd0; req_addr = '0; req_din = 32'd0;
        step;
        chk_en = 1;
        step; step;
        check("rst_ack", ack, 4'd0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_addr", mem_addr, 25'd0);
        reset = 0;

        // CPU read, L=3
        step;
        mem_lat = 3; mem_data = 8'h5A;
        req_addr[2*AW +: AW] = 25'h1234; req_we[2] = 0; req = 4'b0100; n0 = cyc;
        wait_ack(2, 20, at, e);
        check("t1_ack_lat", at - n0, 6);
        check("t1_rdata", rdata, 8'h5A);
        check("t1_strobe_lat", s_cyc - n0, 1);
        check("t1_strobe_addr", s_addr, 25'h1234);
        check("t1_strobe_rd", s_we, 1'b0);
        step; req = 4'd0;

        // Loader write and CPU read together
        step;
        mem_lat = 3; mem_data = 8'h77; err_seen = 4'd0;
        req_addr[0 +: AW] = 25'h0ABCD; req_din[7:0] = 8'h3C; req_we[0] = 1;
        req_addr[2*AW +: AW] = 25'h2222; req_we[2] = 0;
        req = 4'b0101; n0 = cyc;
        wait_ack(0, 20, at, e);
        check("t2_load_lat", at - n0, 6);
        check("t2_strobe_we", s_we, 1'b1);
        check("t2_strobe_din", s_din, 8'h3C);
        check("t2_strobe_addr", s_addr, 25'h0ABCD);
        check("t2_rdata_kept", rdata, 8'h5A);
        step; req[0] = 0; req_we[0] = 0;
        wait_ack(2, 20, at, e);
        check("t2_cpu_lat", at - n0, 13);
        check("t2_cpu_rdata", rdata, 8'h77);
        check("t2_no_err", err_seen, 4'd0);
        step; req = 4'd0;

        // Video continuous, FDD pending: FDD ages in after 15 cycles
        step;
        mem_lat = 1; mem_data = 8'h11;
        req_addr[1*AW +: AW] = 25'h100; req_addr[3*AW +: AW] = 25'h300;
        a0 = ack_cnt[1];
        req = 4'b1010; n0 = cyc;
        wait_ack(3, 40, at, e);
        check("t3_fdd_lat", at - n0, 19);
        check("t3_vid_before", ack_cnt[1] - a0, 3);
        first = at;
        // FDD keeps requesting: its age must restart from 0 after its ack
        wait_ack(3, 40, at, e);
        check("t3_fdd_again", at - first, 20);
        step; req = 4'd0;

        // Watchdog expiry on a CPU read
        repeat (3) step;
        mem_lat = 0; err_seen = 4'd0;
        req_addr[2*AW +: AW] = 25'h1FFFFFF; req_we[2] = 0; req = 4'b0100; n0 = cyc;
        wait_ack(2, 100, at, e);
        check("t4_lat", at - n0, 66);
        check("t4_err", e, 1'b1);
        check("t4_rdata", rdata, 8'hFF);
        step; req = 4'd0;

        // Ready on the last WAIT cycle still counts as success
        step;
        mem_lat = 63; mem_data = 8'h81;
        req = 4'b0100; n0 = cyc;
        wait_ack(2, 100, at, e);
        check("t4b_lat", at - n0, 66);
        check("t4b_err", e, 1'b0);
        check("t4b_rdata", rdata, 8'h81);
        step; req = 4'd0;

        // Reset during WAIT, late ready afterwards
        step;
        mem_lat = 5; mem_data = 8'h42;
        req_addr[2*AW +: AW] = 25'h0F0F0; req = 4'b0100;
        step; step; step;
        reset = 1; req = 4'd0;
        step; reset = 0;
        a0 = ack_cnt[2]; s0 = n_strobe;
        repeat (8) step;
        check("t5_no_ack", ack_cnt[2] - a0, 0);
        check("t5_no_strobe", n_strobe - s0, 0);
        check("t5_addr", mem_addr, 25'd0);
        check("t5_rdata", rdata, 8'h00);
        mem_lat = 2; mem_data = 8'h99;
        req = 4'b0100; n0 = cyc;
        wait_ack(2, 20, at, e);
        check("t5_after_lat", at - n0, 5);
        check("t5_after_rdata", rdata, 8'h99);
        step; req = 4'd0;

        // CPU drops req one cycle after ISSUE
        step;
        mem_lat = 3; mem_data = 8'hC3;
        a0 = ack_cnt[2]; s0 = n_strobe;
        req = 4'b0100; n0 = cyc;
        step; step; req = 4'd0;
        wait_ack(2, 20, at, e);
        check("t6_lat", at - n0, 6);
        check("t6_rdata", rdata, 8'hC3);
        repeat (10) step;
        check("t6_one_strobe", n_strobe - s0, 1);
        check("t6_one_ack", ack_cnt[2] - a0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 8-bit SDRAM-backed memory port among four requesters: ROM/disk loader, video fetch, CPU, and FDD buffer reader.
- Priority is fixed, with anti-starvation aging.
- Each transaction runs as one strobe/ready exchange with the memory controller, guarded by a watchdog.
- Sits between the requesters and the sram instance in the top level; it replaces the ad-hoc address/we/rd muxing there.

Parameters:
- AW, 25, address width of every requester and of the memory port.
- MAX_WAIT, 15, cycles a pending non-loader requester waits before it is promoted (aged).
- TIMEOUT, 63, cycles allowed in WAIT for mem_ready before the transaction is aborted.

Ports:
- clk_sys  in  1  system clock, 96 MHz.
- reset  in  1  synchronous, active-high.
- req  in  4  per-requester request level; index 0=loader, 1=video, 2=CPU, 3=FDD.
- req_we  in  4  per-requester write flag (1=write, 0=read).
- req_addr  in  4*AW  per-requester address; requester i occupies bits [i*AW +: AW].
- req_din  in  32  per-requester write data; requester i occupies bits [i*8 +: 8].
- ack  out  4  one-cycle completion pulse per requester.
- err  out  4  one-cycle pulse coincident with ack when the transaction timed out.
- rdata  out  8  read data; valid in the ack cycle and held until the next ack.
- mem_addr  out  AW  memory address.
- mem_din  out  8  memory write data.
- mem_we  out  1  one-cycle write strobe.
- mem_rd  out  1  one-cycle read strobe.
- mem_dout  in  8  memory read data.
- mem_ready  in  1  completion pulse from memory.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- Reset values: all outputs 0, rdata=0, all aging counters 0.
- IDLE: if any req bit is set, the winner is latched into grant (2 bits), together with its addr, din and we. Next state is ISSUE. With no req, stay in IDLE.
- Winner selection, evaluated in IDLE:
  1. req[0] (loader) always wins.
  2. Otherwise, the aged requesters (wait_cnt==MAX_WAIT) win, lowest index first.
  3. Otherwise, the lowest pending index wins.
- ISSUE: drive mem_rd or mem_we high for exactly this cycle, with the latched mem_addr and mem_din. mem_ready is ignored in this state. Next state is WAIT.
- WAIT:
  - On mem_ready: capture mem_dout into a holding register (reads only) and go to DONE.
  - Watchdog: a counter clears on entry and increments each cycle. When it reaches TIMEOUT without mem_ready, capture 8'hFF, set the abort flag and go to DONE.
- DONE: pulse ack[grant], and err[grant] if aborted. Update rdata from the holding register (writes leave rdata unchanged; aborts set it to FF). Next state is IDLE.
- mem_addr and mem_din hold their latched values from ISSUE through DONE.
- Latency from req seen in IDLE (cycle N):
  - Strobe at N+1.
  - mem_ready at N+1+L, with L≥1.
  - ack at N+3+L.
  - The next grant is decided at N+4+L, so at most one transaction is in flight.
- Requester protocol: hold req, req_we, req_addr and req_din stable until ack. Dropping req after grant does not cancel the transaction; ack still pulses.
- Aging: wait_cnt[i] (4 bits, i=1..3) increments each cycle that req[i]=1 and requester i is not the current grant. It saturates at MAX_WAIT and clears in that requester's DONE cycle or when req[i]=0. The loader has no counter.
- Simultaneous events:
  - mem_ready in the same cycle as the watchdog expiry counts as success.
  - A new req arriving during ISSUE, WAIT or DONE waits for IDLE.
- Reset mid-transaction: the FSM returns to IDLE and the in-flight memory operation is abandoned. A late mem_ready arriving in IDLE is ignored. No ack is generated.

Decomposition:
- Package mem_arb_pkg:
  - Index constants REQ_LOAD=0, REQ_VID=1, REQ_CPU=2, REQ_FDD=3.
  - State enum arb_state_t {IDLE, ISSUE, WAIT, DONE}.
  - Default MAX_WAIT and TIMEOUT values.
- Sub-module mem_arb_pick: combinational winner selection from req and the aged flags; outputs a 2-bit index and a valid bit.
- FSM, aging counters and watchdog live in mem_arbiter.

Test Plan:
- CPU read only, req=4'b0100, addr=0x1234, memory L=3 returning 0x5A: mem_rd pulses one cycle with mem_addr=0x1234; ack[2] arrives 6 cycles after req; rdata=0x5A.
- Loader write and CPU read requested in the same cycle: loader granted first (mem_we, mem_din=req_din[7:0]); CPU is acked after the loader's ack; no err.
- Video requesting continuously while FDD is pending: once wait_cnt[3] reaches 15, the next IDLE grants FDD ahead of video; wait_cnt[3] returns to 0 after its ack.
- Memory never asserts mem_ready on a CPU read: after 63 WAIT cycles, ack[2] and err[2] pulse together and rdata=0xFF.
- Reset asserted during WAIT, then mem_ready arrives: no ack, FSM stays in IDLE, all outputs 0; a subsequent request completes normally.
- CPU drops req one cycle after ISSUE: the transaction still completes, ack[2] pulses once, and no second strobe is issued.
